fx_pt_add_rnd_pipe: RTL and testbench
=====================================

Name:
fx_pt_add_rnd_pipe

Overview:
- Parametrised successor to the single-register rounding fixed-point adder.
- Two-stage pipelined adder of two fixed-point operands with independent integer/fraction widths.
- Adds a runtime-selectable rounding mode and valid/ready flow control on both sides.
- Sits between producer and consumer datapath blocks that may stall.

Parameters:
- SN, 1, number format: 0 unsigned, 1 two's complement, 2 sign-magnitude (MSB sign).
- AIW, 2, operand A integer bits (sign included for SN 1/2).
- AFW, 10, operand A fraction bits.
- BIW, 4, operand B integer bits.
- BFW, 8, operand B fraction bits.
- SFW, 3, result fraction bits.
- SIW, derived (not overridable) = max(AIW,BIW)+2, result integer bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  AIW+AFW  operand A.
- in_b  in  BIW+BFW  operand B.
- rnd_mode  in  2  rounding mode, sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  SIW+SFW  rounded sum, registered.

Behaviour:
- Reset (rst=0, async): both stage valids 0, sum=0, out_valid=0. in_ready=1 whenever out_valid=0, so it is 1 during reset.
- Stall-all pipeline: adv = !out_valid | out_ready; in_ready = adv (combinational).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage 1 on adv:
  - Capture operand A, operand B and rnd_mode.
  - Align both operands to FW = max(AFW,BFW) by zero-padding the fraction LSBs.
  - Extend to SIW integer bits: sign-extend for SN=1, zero-extend for SN 0/2.
  - Full-precision add; for SN=2 a signed add of the magnitudes, result held as sign and magnitude.
  - s1_valid <= in_valid.
- Stage 2 on adv: round to SFW; sum <= result; out_valid <= s1_valid.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1 per cycle.
- When not advancing, all stage registers hold and sum is stable while out_valid=1 & out_ready=0.
- If SFW >= FW: zero-pad the fraction LSBs, exact result, rnd_mode ignored.
- If SFW < FW: discard D = FW-SFW LSBs.
  - rnd_mode 0: round half away from zero. For SN=0 this is half-up.
  - rnd_mode 1: truncate. Floor for SN 0/1; magnitude toward zero for SN=2.
  - rnd_mode 2: convergent (half-to-even); non-ties round to nearest.
  - rnd_mode 3: reserved, behaves as mode 0.
- SN=2: result magnitude 0 always encodes +0 (sign bit 0), including -0 inputs.
- Overflow is impossible: SIW = max(AIW,BIW)+2 covers the worst sum plus a rounding increment. No saturation logic.
- in_valid asserted while in_ready=0: not captured; the producer must hold the operands.
- Reset asserted mid-operation: in-flight data is discarded, no output generated for it.

Optional Feature:
- Macro FX_INEXACT_EN.
- Defined:
  - Adds output port out_inexact (1 bit), registered alongside sum and reset to 0.
  - out_inexact = 1 when any discarded LSB of that result was nonzero (SFW < FW only).
  - Always 0 when SFW >= FW.
- Undefined: port absent and no extra logic. Sum behaviour identical in both builds.

Test Plan:
- All tests use defaults SN=1, A=2.10, B=4.8, S=6.3 (9-bit sum) unless stated.
- Latency/min values: in_a=12'hFFF, in_b=12'hFFF, mode 0, out_ready=1 -> sum=9'h000, out_valid high exactly 2 cycles after accept.
- Max positive: in_a=12'h7FF, in_b=12'h7FF, mode 0 -> sum=9'h050 (79.96 rounds to 80).
- Positive ties:
  - in_a=12'h040, in_b=0 (0.5 LSB): mode 0 -> 9'h001, mode 1 -> 9'h000, mode 2 -> 9'h000.
  - in_a=12'h0C0 (1.5 LSB), mode 2 -> 9'h002.
- Negative ties and mode 3:
  - in_a=12'hFC0, in_b=0 (-0.5 LSB): mode 0 -> 9'h1FF, mode 1 -> 9'h1FF, mode 2 -> 9'h000.
  - mode 3 on the same input -> 9'h1FF.
- Backpressure:
  - out_ready=0, push X then Y on consecutive cycles -> in_ready=0 on the third cycle, sum holds X.
  - Raise out_ready -> X then Y delivered in order, no loss or duplication, in_ready back to 1.
- Reset and SN=2:
  - rst low with both stages full -> out_valid and sum drop to 0 immediately (asynchronous), no stale output after release.
  - SN=2 build: in_a=12'h800 (-0), in_b=12'h000 -> sum=0 with sign bit 0.

Source files
------------

// File: rtl/fx_pt_add_rnd_pipe.sv
// Two-stage valid/ready fixed-point adder with runtime rounding mode.
// Define FX_INEXACT_EN to add the registered out_inexact flag.
module fx_pt_add_rnd_pipe #(
  parameter int SN  = 1,
  parameter int AIW = 2,
  parameter int AFW = 10,
  parameter int BIW = 4,
  parameter int BFW = 8,
  parameter int SFW = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [AIW+AFW-1:0]                          in_a,
  input  logic [BIW+BFW-1:0]                          in_b,
  input  logic [1:0]                                  rnd_mode,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [((AIW > BIW) ? AIW : BIW)+2+SFW-1:0]  sum
`ifdef FX_INEXACT_EN
  ,
  output logic                                        out_inexact
`endif
);

  localparam int SIW = ((AIW > BIW) ? AIW : BIW) + 2;
  localparam int FW  = (AFW > BFW) ? AFW : BFW;
  localparam int AW  = AIW + AFW;
  localparam int BW  = BIW + BFW;
  localparam int VW  = SIW + FW + 1;
  localparam int OW  = SIW + SFW;

  logic                 adv;
  logic signed [VW-1:0] a_ext, b_ext;
  logic signed [VW-1:0] s1_val_d, s1_val_q;
  logic [1:0]           s1_mode_d, s1_mode_q;
  logic                 s1_valid_d, s1_valid_q;
  logic signed [OW:0]   rnd_val;
  logic [OW-1:0]        sum_fmt;
  logic [OW-1:0]        sum_d, sum_q;
  logic                 out_valid_d, out_valid_q;
`ifdef FX_INEXACT_EN
  logic                 rnd_inexact;
  logic                 out_inexact_d, out_inexact_q;
`endif

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

  // Operands become signed values in units of 2^-FW; sign-magnitude is converted here.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    if (SN == 1) begin
      a_ext = VW'($signed(in_a));
      b_ext = VW'($signed(in_b));
    end else if (SN == 2) begin
      a_ext = VW'(in_a[AW-2:0]);
      b_ext = VW'(in_b[BW-2:0]);
      if (in_a[AW-1]) a_ext = -a_ext;
      if (in_b[BW-1]) b_ext = -b_ext;
    end else begin
      a_ext = VW'(in_a);
      b_ext = VW'(in_b);
    end
    a_ext = a_ext <<< (FW - AFW);
    b_ext = b_ext <<< (FW - BFW);
  end

  always_comb begin
    s1_val_d   = s1_val_q;
    s1_mode_d  = s1_mode_q;
    s1_valid_d = s1_valid_q;
    if (adv) begin
      s1_val_d   = a_ext + b_ext;
      s1_mode_d  = rnd_mode;
      s1_valid_d = in_valid;
    end
  end

  generate
    if (SFW < FW) begin : g_rnd
      localparam int D = FW - SFW;
      localparam logic [D-1:0] HALF = D'(1) << (D - 1);
      logic signed [VW-D-1:0] q;
      logic [D-1:0]           r;
      logic                   neg, gt_half, eq_half, up;

      always_comb begin
        q       = s1_val_q[VW-1:D];
        r       = s1_val_q[D-1:0];
        neg     = s1_val_q[VW-1];
        gt_half = (r > HALF);
        eq_half = (r == HALF);
        up      = 1'b0;
        // q is the floor; each mode decides whether to step up by one LSB.
        case (s1_mode_q)
          2'd1:    up = (SN == 2) ? (neg && (r != '0)) : 1'b0;
          2'd2:    up = gt_half || (eq_half && q[0]);
          default: up = neg ? gt_half : (gt_half || eq_half);
        endcase
        rnd_val = q + (VW-D)'(up);
      end
`ifdef FX_INEXACT_EN
      assign rnd_inexact = (r != '0);
`endif
    end else begin : g_pad
      logic unused_mode;
      assign rnd_val     = (OW+1)'(s1_val_q) <<< (SFW - FW);
      assign unused_mode = ^s1_mode_q;
`ifdef FX_INEXACT_EN
      assign rnd_inexact = 1'b0;
`endif
    end
  endgenerate

  generate
    if (SN == 2) begin : g_fmt_sm
      logic [OW:0] mag;
      logic        unused_mag;
      // A zero result is never negative, so -0 collapses to +0 here.
      assign mag        = rnd_val[OW] ? -rnd_val : rnd_val;
      assign sum_fmt    = {rnd_val[OW], mag[OW-2:0]};
      assign unused_mag = ^mag[OW:OW-1];
    end else begin : g_fmt_2c
      logic unused_top;
      assign sum_fmt    = rnd_val[OW-1:0];
      assign unused_top = rnd_val[OW];
    end
  endgenerate

  always_comb begin
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      sum_d       = sum_fmt;
      out_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_val_q    <= '0;
      s1_mode_q   <= '0;
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_val_q    <= s1_val_d;
      s1_mode_q   <= s1_mode_d;
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FX_INEXACT_EN
  assign out_inexact_d = adv ? rnd_inexact : out_inexact_q;
  assign out_inexact   = out_inexact_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_inexact_q <= 1'b0;
    else      out_inexact_q <= out_inexact_d;
  end
`endif

endmodule

// File: tb/tb_fx_pt_add_rnd_pipe.sv
// Bench for fx_pt_add_rnd_pipe: default two's-complement instance plus an SN=2 instance,
// driven in lockstep and checked against an integer reference model.
module tb_fx_pt_add_rnd_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic        in_ready, in_ready_sm;
  logic        out_valid, out_valid_sm;
  logic [11:0] in_a, in_b;
  logic [1:0]  rnd_mode;
  logic [8:0]  sum, sum_sm;
`ifdef FX_INEXACT_EN
  logic        out_inexact, out_inexact_sm;
`endif

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_sm_q[$];
  bit         exp_ix_q[$];

  always #5 clk = ~clk;

  fx_pt_add_rnd_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef FX_INEXACT_EN
    , .out_inexact(out_inexact)
`endif
  );

  fx_pt_add_rnd_pipe #(.SN(2)) u_dut_sm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sm),
    .in_a(in_a), .in_b(in_b), .rnd_mode(rnd_mode),
    .out_valid(out_valid_sm), .out_ready(out_ready), .sum(sum_sm)
`ifdef FX_INEXACT_EN
    , .out_inexact(out_inexact_sm)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Operand value in units of 2^-10.
  function automatic longint to_val(input logic [11:0] x, input int iw, input int fw, input int sn);
    longint v;
    longint m;
    if (sn == 2) begin
      m = longint'(x) & ((longint'(1) << (iw + fw - 1)) - 1);
      v = x[iw+fw-1] ? -m : m;
    end else begin
      v = longint'(x);
      if (sn == 1 && x[iw+fw-1]) v = v - (longint'(1) << (iw + fw));
    end
    return v * (longint'(1) << (10 - fw));
  endfunction

  // Round a 2^-10 value to 2^-3 units (128 input units per output LSB).
  function automatic logic [8:0] ref_sum(input longint v, input int mode, input int sn);
    longint m, q, r, res;
    bit neg;
    logic [8:0] o;
    neg = (v < 0);
    m   = neg ? -v : v;
    q   = m / 128;
    r   = m % 128;
    case (mode)
      1:       if (neg && sn != 2 && r != 0) q = q + 1;
      2:       if (r > 64 || (r == 64 && (q % 2) == 1)) q = q + 1;
      default: if (r >= 64) q = q + 1;
    endcase
    res = neg ? -q : q;
    if (sn == 2) begin
      o[8]   = (res < 0);
      o[7:0] = q[7:0];
    end else begin
      o = res[8:0];
    end
    return o;
  endfunction

  function automatic longint val1(input logic [11:0] a, input logic [11:0] b);
    return to_val(a, 2, 10, 1) + to_val(b, 4, 8, 1);
  endfunction

  function automatic longint val2(input logic [11:0] a, input logic [11:0] b);
    return to_val(a, 2, 10, 2) + to_val(b, 4, 8, 2);
  endfunction

  // Single accept on an idle pipeline with out_ready high; checks 2-cycle latency.
  task automatic directed(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [1:0] m, input logic [8:0] exp, input logic [8:0] exp_sm);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    rnd_mode  = m;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 12'($urandom);
    in_b     = 12'($urandom);
    rnd_mode = 2'($urandom);
    @(negedge clk);
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, sum, exp);
    chk({tag, "_sm"}, sum_sm, exp_sm);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_once"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic cycle();
    longint v;
    logic [8:0] e;
    bit ix;
    @(negedge clk);
    chk("rdy_rule", in_ready, !out_valid || out_ready);
    if (in_valid && in_ready) begin
      v = val1(in_a, in_b);
      exp_q.push_back(ref_sum(v, rnd_mode, 1));
      exp_ix_q.push_back((v % 128) != 0);
    end
    if (in_valid && in_ready_sm)
      exp_sm_q.push_back(ref_sum(val2(in_a, in_b), rnd_mode, 2));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", out_valid, 0);
      else begin
        e  = exp_q.pop_front();
        ix = exp_ix_q.pop_front();
        chk("rnd_sum", sum, e);
`ifdef FX_INEXACT_EN
        chk("inexact", out_inexact, ix);
`else
        if (ix && e === 9'bx) chk("ix_unreach", sum, 0);
`endif
      end
    end
    if (out_valid_sm && out_ready) begin
      if (exp_sm_q.size() == 0) chk("extra_out_sm", out_valid_sm, 0);
      else chk("rnd_sum_sm", sum_sm, exp_sm_q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    rnd_mode  = '0;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_rdy", in_ready, 1);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    directed("min",     12'hFFF, 12'hFFF, 2'd0, 9'h000, ref_sum(val2(12'hFFF, 12'hFFF), 0, 2));
    directed("max",     12'h7FF, 12'h7FF, 2'd0, 9'h050, ref_sum(val2(12'h7FF, 12'h7FF), 0, 2));
    directed("tie_m0",  12'h040, 12'h000, 2'd0, 9'h001, 9'h001);
    directed("tie_m1",  12'h040, 12'h000, 2'd1, 9'h000, 9'h000);
    directed("tie_m2",  12'h040, 12'h000, 2'd2, 9'h000, 9'h000);
    directed("tie15",   12'h0C0, 12'h000, 2'd2, 9'h002, 9'h002);
    directed("ntie_m0", 12'hFC0, 12'h000, 2'd0, 9'h1FF, ref_sum(val2(12'hFC0, 12'h000), 0, 2));
    directed("ntie_m1", 12'hFC0, 12'h000, 2'd1, 9'h1FF, ref_sum(val2(12'hFC0, 12'h000), 1, 2));
    directed("ntie_m2", 12'hFC0, 12'h000, 2'd2, 9'h000, ref_sum(val2(12'hFC0, 12'h000), 2, 2));
    directed("ntie_m3", 12'hFC0, 12'h000, 2'd3, 9'h1FF, ref_sum(val2(12'hFC0, 12'h000), 3, 2));
    directed("neg0",    12'h800, 12'h000, 2'd0, 9'h1F0, 9'h000);
    directed("sm_tie",  12'h840, 12'h000, 2'd0, ref_sum(val1(12'h840, 12'h000), 0, 1), 9'h101);

    // Backpressure: X then Y with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 12'h040; in_b = 12'h000; rnd_mode = 2'd0;
    @(negedge clk); chk("bp_rdy1", in_ready, 1);
    @(posedge clk); #1;
    in_a = 12'h0C0; rnd_mode = 2'd2;
    @(negedge clk); chk("bp_rdy2", in_ready, 1);
    @(posedge clk); #1;
    in_a = 12'h100; rnd_mode = 2'd0;
    @(negedge clk);
    chk("bp_rdy3", in_ready, 0);
    chk("bp_vld3", out_valid, 1);
    chk("bp_hold3", sum, 9'h001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rdy4", in_ready, 0);
    chk("bp_hold4", sum, 9'h001);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_x_vld", out_valid, 1);
    chk("bp_x", sum, 9'h001);
    chk("bp_rdy5", in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_y_vld", out_valid, 1);
    chk("bp_y", sum, 9'h002);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    @(posedge clk); #1;

    // Randomized traffic with random stalls.
    repeat (400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 12'($urandom);
      in_b      = 12'($urandom);
      rnd_mode  = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_sm_q.size() != 0); i++) cycle();
    chk("drain", exp_q.size(), 0);
    chk("drain_sm", exp_sm_q.size(), 0);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 12'h040; in_b = 12'h000; rnd_mode = 2'd0;
    @(posedge clk); #1;
    in_a = 12'h0C0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_vld", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", out_valid, 0);
    chk("arst_sum", sum, 0);
    chk("arst_rdy", in_ready, 1);
    chk("arst_vld_sm", out_valid_sm, 0);
    #12 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_vld", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
